// File: rtl/play_ctrl_if.sv
// Playback controller bundle: raw buttons in, tone-driver controls and beat position out.
// Latency: none, wires only.
// Backpressure: none; buttons are free-running levels and all outputs are registered status.
interface play_ctrl_if;
   logic       btn_start;
   logic       btn_pause;
   logic       on_off;
   logic       pau_flag;
   logic       beat_tick;
   logic [7:0] beat_idx;
   logic       song_done;
   logic [1:0] state;

   modport master (
      input  btn_start, btn_pause,
      output on_off, pau_flag, beat_tick, beat_idx, song_done, state
   );

   modport slave (
      output btn_start, btn_pause,
      input  on_off, pau_flag, beat_tick, beat_idx, song_done, state
   );
endinterface

// File: rtl/play_ctrl.sv
// Playback controller: debounced start/stop and pause/resume buttons drive a 4-state song FSM with beat divider.
// Latency: raw press to state change is DEBOUNCE_CYC+4 edges; all outputs registered.
// Backpressure: none; a press is a one-cycle pulse that is acted on immediately, held buttons give one pulse.
module play_ctrl #(
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned BEAT_DIV     = 10000000,
   parameter int unsigned SONG_LEN     = 140,
   parameter int unsigned REPEAT       = 0
) (
   input logic          CLK_50M,
   input logic          rst,
   play_ctrl_if.master  bus
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned DIV_W = $clog2(BEAT_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);
   localparam logic [7:0]       IDX_LAST = 8'(SONG_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_PLAY  = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   // bit 0 = start/stop button, bit 1 = pause/resume button
   logic [1:0]       raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       db_lvl;
   logic [1:0]       db_dly;
   logic [1:0]       press;
   logic [CNT_W-1:0] db_cnt [2];
   logic             start_p;
   logic             pause_p;

   state_t           state_q, state_nx;
   logic [DIV_W-1:0] div_q, div_nx;
   logic [7:0]       idx_q, idx_nx;
   logic             tick_q, tick_nx;
   logic             done_q, done_nx;
   logic             on_q;
   logic             pau_q;
   logic             wrap;

   assign raw     = {bus.btn_pause, bus.btn_start};
   assign start_p = press[0];
   assign pause_p = press[1];
   assign wrap    = (div_q == DIV_LAST);

   // Synchronise each button, accept a new level after DEBOUNCE_CYC differing cycles, pulse on its rising edge
   always_ff @(posedge CLK_50M) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         db_lvl    <= '0;
         db_dly    <= '0;
         press     <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         db_dly <= db_lvl;
         press  <= db_lvl & ~db_dly;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               db_cnt[i] <= '0;
               db_lvl[i] <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Next state, beat divider and beat index; start beats pause, start beats a beat wrap
   always_comb begin
      state_nx = state_q;
      div_nx   = div_q;
      idx_nx   = idx_q;
      tick_nx  = 1'b0;
      done_nx  = 1'b0;
      case (state_q)
         S_IDLE: begin
            div_nx = '0;
            idx_nx = '0;
            if (start_p) begin
               state_nx = S_PLAY;
               tick_nx  = 1'b1;
            end
         end
         S_PLAY: begin
            if (start_p) begin
               state_nx = S_IDLE;
               div_nx   = '0;
               idx_nx   = '0;
            end else begin
               if (wrap) begin
                  div_nx = '0;
                  if (idx_q < IDX_LAST) begin
                     idx_nx  = idx_q + 8'd1;
                     tick_nx = 1'b1;
                  end else if (REPEAT != 0) begin
                     idx_nx  = '0;
                     tick_nx = 1'b1;
                  end else begin
                     state_nx = S_DONE;
                     done_nx  = 1'b1;
                  end
               end else begin
                  div_nx = div_q + 1'b1;
               end
               // a pause landing on the final wrap loses to end of song
               if (pause_p && (state_nx != S_DONE)) state_nx = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (start_p) begin
               state_nx = S_IDLE;
               div_nx   = '0;
               idx_nx   = '0;
            end else if (pause_p) begin
               state_nx = S_PLAY;
            end
         end
         default: begin
            div_nx = '0;
            if (start_p) begin
               state_nx = S_PLAY;
               idx_nx   = '0;
               tick_nx  = 1'b1;
            end
         end
      endcase
   end

   // State and output registers; on_off/pau_flag follow the next state so they move with it
   always_ff @(posedge CLK_50M) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         idx_q   <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         on_q    <= 1'b0;
         pau_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         div_q   <= div_nx;
         idx_q   <= idx_nx;
         tick_q  <= tick_nx;
         done_q  <= done_nx;
         on_q    <= (state_nx == S_PLAY) || (state_nx == S_PAUSE);
         pau_q   <= (state_nx == S_PAUSE);
      end
   end

   assign bus.state     = state_q;
   assign bus.on_off    = on_q;
   assign bus.pau_flag  = pau_q;
   assign bus.beat_tick = tick_q;
   assign bus.song_done = done_q;
   assign bus.beat_idx  = idx_q;

endmodule
